// File: rtl/midi_tx_fifo.sv
// midi_tx_fifo: queued MIDI message serializer, 8N1 at sysclk/BAUD_DIV with optional running-status compression
module midi_tx_fifo #(
  parameter int BAUD_DIV       = 3200,
  parameter int FIFO_DEPTH     = 8,
  parameter int RUNNING_STATUS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          msg_valid,
  output logic                          msg_ready,
  input  logic [7:0]                    status,
  input  logic [7:0]                    data1,
  input  logic [7:0]                    data2,
  input  logic [1:0]                    msg_len,
  output logic                          midi_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    st, bit_idx;
  logic [CW-1:0] cnt;
  logic [1:0]    idx, len;
  logic [7:0]    s_b, d1_b, d2_b, last_status, cur;
  logic          push, pop, tick, chan, skip;
  assign msg_ready = fifo_level != LW'(FIFO_DEPTH);
  assign push      = msg_valid && msg_ready;
  assign pop       = st == IDLE && fifo_level != '0;
  assign busy      = st != IDLE || fifo_level != '0;
  assign tick      = cnt == CW'(BAUD_DIV - 1);
  assign cur       = idx == 2'd0 ? s_b : idx == 2'd1 ? d1_b : d2_b;
  assign chan      = s_b >= 8'h80 && s_b <= 8'hEF;
  assign skip      = RUNNING_STATUS != 0 && chan && s_b == last_status && len >= 2'd2;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {msg_len, data2, data1, status};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st          <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      idx         <= '0;
      len         <= '0;
      s_b         <= '0;
      d1_b        <= '0;
      d2_b        <= '0;
      last_status <= '0;
      midi_tx     <= 1'b1;
    end else begin
      cnt <= (st == START || st == DATA || st == STOP) && !tick ? cnt + CW'(1) : '0;
      case (st)
        IDLE: if (pop) begin
          {len, d2_b, d1_b, s_b} <= mem[rd_ptr];
          st <= LOAD;
        end
        LOAD: begin
          idx <= skip ? 2'd1 : 2'd0;
          if (len == 2'd0) st <= IDLE;
          else begin
            st      <= START;
            midi_tx <= 1'b0;
            if (chan) last_status <= s_b;
            else if (s_b >= 8'hF0 && s_b <= 8'hF7) last_status <= 8'h00;
          end
        end
        START: if (tick) begin
          st      <= DATA;
          bit_idx <= '0;
          midi_tx <= cur[0];
        end
        DATA: if (tick) begin
          if (bit_idx == 3'd7) begin
            st      <= STOP;
            midi_tx <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            midi_tx <= cur[bit_idx + 3'd1];
          end
        end
        STOP: if (tick) begin
          if (idx + 2'd1 < len) begin
            idx     <= idx + 2'd1;
            st      <= START;
            midi_tx <= 1'b0;
          end else st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
endmodule
